// File: rtl/button_cmd_scheduler.sv
// button_cmd_scheduler: arbitrates button press pulses into one valid/ready command stream
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   btn_press  one-cycle press pulses per button
//   btn_level  debounced held levels per button (used only with auto-repeat)
//   cmd_ready  consumer accepts the offered command
//   cmd_valid  command offered
//   cmd_id     index of the offered button
//   cmd_repeat offered command is an auto-repeat
//   cmd_drop   sticky flag: an event hit an already-pending slot
// Define BTN_AUTOREPEAT_EN to build the hold-to-repeat tracker.
module button_cmd_scheduler #(
    parameter int N_BTN         = 4,
    parameter int ID_W          = 2,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_press,
    input  logic [N_BTN-1:0] btn_level,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [ID_W-1:0]  cmd_id,
    output logic             cmd_repeat,
    output logic             cmd_drop
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t state, state_d;
    logic [N_BTN-1:0] pending, rep, hit, clr, set, load;
    logic [ID_W-1:0]  sel, trk_id, id_d;
    logic             tick, accept, valid_d, rpt_d;

    assign accept = (state == OFFER) && cmd_ready;

    genvar g;
    for (g = 0; g < N_BTN; g++) begin : slot
        assign hit[g] = tick && (trk_id == ID_W'(g));
        assign clr[g] = accept && (cmd_id == ID_W'(g));
    end

    // A set lands when the slot is free or being cleared this cycle; otherwise it is dropped.
    assign set  = btn_press | hit;
    assign load = set & (~pending | clr);

    always_comb begin
        sel = '0;
        for (int i = N_BTN - 1; i >= 0; i--)
            if (pending[i]) sel = ID_W'(i);
    end

    always_comb begin
        state_d = state;
        valid_d = cmd_valid;
        id_d    = cmd_id;
        rpt_d   = cmd_repeat;
        if (state == IDLE) begin
            if (|pending) begin
                state_d = OFFER;
                valid_d = 1'b1;
                id_d    = sel;
                rpt_d   = rep[sel];
            end
        end else if (cmd_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cmd_valid  <= 1'b0;
            cmd_id     <= '0;
            cmd_repeat <= 1'b0;
            cmd_drop   <= 1'b0;
            pending    <= '0;
            rep        <= '0;
        end else begin
            state      <= state_d;
            cmd_valid  <= valid_d;
            cmd_id     <= id_d;
            cmd_repeat <= rpt_d;
            cmd_drop   <= cmd_drop | (|(set & pending & ~clr));
            pending    <= set | (pending & ~clr);
            rep        <= (rep & ~load) | (load & hit & ~btn_press);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic             trk_on, first, held;
    logic [CNT_W-1:0] cnt;

    assign held = trk_on && btn_level[trk_id];
    // The first tick waits the hold time; later ticks use the shorter repeat period.
    assign tick = held && (cnt == (first ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(REPEAT_CYCLES - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_on <= 1'b0;
            trk_id <= '0;
            first  <= 1'b1;
            cnt    <= '0;
        end else if (accept && !cmd_repeat) begin
            trk_on <= 1'b1;
            trk_id <= cmd_id;
            first  <= 1'b1;
            cnt    <= '0;
        end else if (!held) begin
            trk_on <= 1'b0;
            cnt    <= '0;
        end else if (tick) begin
            first  <= 1'b0;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end
`else
    logic unused_level;
    assign unused_level = ^btn_level;
    assign tick         = 1'b0;
    assign trk_id       = '0;
`endif
endmodule

// File: tb/tb_button_cmd_scheduler.sv
// tb_button_cmd_scheduler: directed and random stimulus checked against a behavioural model
module tb_button_cmd_scheduler;
    localparam int N = 4, IW = 2, HOLD = 8, REP = 4, CW = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b0, cmd_ready = 1'b0;
    logic [N-1:0]  btn_press = '0, btn_level = '0;
    logic          cmd_valid, cmd_repeat, cmd_drop;
    logic [IW-1:0] cmd_id;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    button_cmd_scheduler #(.N_BTN(N), .ID_W(IW), .HOLD_CYCLES(HOLD),
                           .REPEAT_CYCLES(REP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .btn_press(btn_press), .btn_level(btn_level),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
        .cmd_repeat(cmd_repeat), .cmd_drop(cmd_drop));

    // Model: pending flags per button, one offer register, and a hold age since grant.
    bit m_pend[N], m_rep[N];
    bit m_offer, m_rpt, m_drop, m_trk;
    int m_id, m_trk_id, m_age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_rep[i]  = 1'b0;
        end
        m_offer = 0; m_rpt = 0; m_drop = 0; m_trk = 0;
        m_id = 0; m_trk_id = 0; m_age = 0;
    endtask

    task automatic model_step();
        bit tick, acc, old_rpt, set, clr;
        bit op[N], orp[N];
        int old_id, age1;
        if (!rst) begin
            model_reset();
            return;
        end
        tick = 0;
        age1 = m_age + 1;
        // Ticks fall at HOLD, HOLD+REP, HOLD+2*REP ... held cycles after the grant.
        if (AR && m_trk && btn_level[m_trk_id])
            tick = (age1 >= HOLD) && ((age1 - HOLD) % REP == 0);
        acc = m_offer && cmd_ready;
        old_id = m_id; old_rpt = m_rpt;
        op = m_pend; orp = m_rep;
        for (int i = 0; i < N; i++) begin
            set = btn_press[i] || (tick && m_trk_id == i);
            clr = acc && old_id == i;
            if (set) begin
                if (op[i] && !clr) m_drop = 1;
                else begin
                    m_pend[i] = 1;
                    m_rep[i]  = !btn_press[i];
                end
            end else if (clr) m_pend[i] = 0;
        end
        if (m_offer) begin
            if (cmd_ready) m_offer = 0;
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (op[i]) begin
                    m_offer = 1;
                    m_id = i;
                    m_rpt = orp[i];
                end
        end
        if (AR) begin
            if (acc && !old_rpt) begin
                m_trk = 1; m_trk_id = old_id; m_age = 0;
            end else if (m_trk && btn_level[m_trk_id]) m_age = age1;
            else begin
                m_trk = 0; m_age = 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("valid", cmd_valid, m_offer);
        chk("drop", cmd_drop, m_drop);
        if (m_offer) begin
            chk("id", cmd_id, m_id);
            chk("repeat", cmd_repeat, m_rpt);
        end
    endtask

    task automatic press(input logic [N-1:0] p);
        btn_press = p;
        cyc();
        btn_press = '0;
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_id", cmd_id, 0);
        chk("rst_repeat", cmd_repeat, 0);
        chk("rst_drop", cmd_drop, 0);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        // single press with ready high
        cmd_ready = 1'b1;
        press(4'b0100);
        chk("t1_latency", cmd_valid, 0);
        cyc();
        chk("t1_valid", cmd_valid, 1);
        chk("t1_id", cmd_id, 2);
        repeat (3) cyc();
        // two simultaneous presses: lowest index first, one idle cycle between
        press(4'b1010);
        repeat (6) cyc();
        chk("t2_nodrop", cmd_drop, 0);
        // stalled offer with a duplicate press
        cmd_ready = 1'b0;
        press(4'b0001);
        cyc();
        press(4'b0001);
        repeat (8) cyc();
        chk("t3_drop", cmd_drop, 1);
        cmd_ready = 1'b1;
        repeat (4) cyc();
        // hold button 3
        btn_level = 4'b1000;
        press(4'b1000);
        repeat (29) cyc();
        btn_level = '0;
        repeat (20) cyc();
        // reset mid-offer
        cmd_ready = 1'b0;
        press(4'b0010);
        cyc();
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("t5_valid", cmd_valid, 0);
        chk("t5_drop", cmd_drop, 0);
        chk("t5_id", cmd_id, 0);
        @(negedge clk);
        cyc();
        rst = 1'b1;
        cmd_ready = 1'b1;
        repeat (10) cyc();
        // random traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(15) == 0) btn_level[i] = ~btn_level[i];
            btn_press = ($urandom_range(5) == 0) ? N'($urandom) : '0;
            cmd_ready = $urandom_range(3) != 0;
            cyc();
        end
        btn_press = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
